// File: rtl/tacho_if.sv
// CSR bus between the I2C slave (master side) and the tachometer block (slave side).
interface tacho_if;
    logic [4:0] csr_a;
    logic [7:0] csr_di;
    logic       csr_we;
    logic [7:0] csr_do;

    modport master (output csr_a, output csr_di, output csr_we, input csr_do);
    modport slave  (input csr_a, input csr_di, input csr_we, output csr_do);
endinterface

// File: rtl/tacho.sv
// Fan tachometer: filters the tach pin, counts rising edges per 1 s gate,
// and exposes a coherent 16-bit result plus a stall interrupt over the CSR bus.
module tacho #(
    parameter logic [4:0]  BASE_ADDR  = 5'h1a,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    tach_in,
    input  logic    ce_1s,
    tacho_if.slave  csr,
    output logic    irq
);

    localparam logic [4:0] ADDR_CTRL = BASE_ADDR;
    localparam logic [4:0] ADDR_CNTH = BASE_ADDR + 5'd1;
    localparam logic [4:0] ADDR_CNTL = BASE_ADDR + 5'd2;
    localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    state_t      state, state_nxt;
    logic        sync1, sync2, filt, filt_d;
    logic [3:0]  fcnt;
    logic        rise;
    logic        en, stall_ie, freeze, stall, valid;
    logic [15:0] cnt, cnt_nxt, cnt_inc, sum, pend, result;
    logic        ctrl_wr, en_clr_wr, latch;
    logic        unused_di;

    assign unused_di = ^{csr.csr_di[7:5], csr.csr_di[3]};

    assign rise      = filt & ~filt_d;
    assign ctrl_wr   = csr.csr_we && (csr.csr_a == ADDR_CTRL);
    assign en_clr_wr = ctrl_wr && !csr.csr_di[0];
    assign cnt_inc   = (rise && cnt != '1) ? cnt + 16'd1 : cnt;
    assign sum       = (cnt == '1) ? cnt : cnt + 16'(rise);
    assign irq       = stall & stall_ie;

    // Synchronize the pin and debounce it; the filtered level only moves after
    // FILTER_LEN consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            filt   <= 1'b1;
            filt_d <= 1'b1;
            fcnt   <= '0;
        end else begin
            sync1  <= tach_in;
            sync2  <= sync1;
            filt_d <= filt;
            if (sync2 != filt) begin
                if (fcnt == FILT_LAST) begin
                    filt <= sync2;
                    fcnt <= '0;
                end else begin
                    fcnt <= fcnt + 4'd1;
                end
            end else begin
                fcnt <= '0;
            end
        end
    end

    // Gate state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next gate state: EN low forces IDLE from anywhere.
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ARM;
                ARM:     if (ce_1s) state_nxt = RUN;
                RUN:     state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Counter update and gate-end latch decision; a CTRL write dropping EN
    // in the gate-end cycle suppresses the latch even though EN is still set.
    always_comb begin
        cnt_nxt = cnt;
        latch   = 1'b0;
        case (state)
            IDLE: cnt_nxt = '0;
            ARM:  cnt_nxt = ce_1s ? '0 : cnt_inc;
            RUN: begin
                if (ce_1s) begin
                    cnt_nxt = '0;
                    latch   = en && !en_clr_wr;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: cnt_nxt = '0;
        endcase
    end

    // Count, pending and published result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            pend   <= '0;
            result <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (latch)   pend   <= sum;
            if (!freeze) result <= pend;
        end
    end

    // CTRL register; a stall detection beats a simultaneous write-1-to-clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en       <= 1'b0;
            stall_ie <= 1'b0;
            freeze   <= 1'b0;
            stall    <= 1'b0;
            valid    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                en       <= csr.csr_di[0];
                stall_ie <= csr.csr_di[1];
                freeze   <= csr.csr_di[2];
            end
            if (latch)     valid <= 1'b1;
            else if (!en)  valid <= 1'b0;
            if (latch && sum == '0)              stall <= 1'b1;
            else if (ctrl_wr && csr.csr_di[4])   stall <= 1'b0;
        end
    end

    // Read mux onto the shared OR-ed bus; zero outside our window.
    always_comb begin
        csr.csr_do = '0;
        case (csr.csr_a)
            ADDR_CTRL: csr.csr_do = {valid, 2'b00, stall, 1'b0, freeze, stall_ie, en};
            ADDR_CNTH: csr.csr_do = result[15:8];
            ADDR_CNTL: csr.csr_do = result[7:0];
            default:   csr.csr_do = '0;
        endcase
    end

endmodule

// File: tb/tb_tacho.sv
// Self-checking bench for tacho: gate results go through a scoreboard queue,
// control/status bits are compared directly.
module tb_tacho;

    localparam logic [4:0] BASE = 5'h1a;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tach_in = 1'b1;
    logic ce_1s = 1'b0;
    logic irq1, irq2;

    tacho_if b1();
    tacho_if b2();

    tacho #(.BASE_ADDR(BASE), .FILTER_LEN(4)) dut (
        .clk(clk), .rst(rst), .tach_in(tach_in), .ce_1s(ce_1s), .csr(b1.slave), .irq(irq1));

    tacho #(.BASE_ADDR(BASE), .FILTER_LEN(2)) dut2 (
        .clk(clk), .rst(rst), .tach_in(tach_in), .ce_1s(ce_1s), .csr(b2.slave), .irq(irq2));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          sel;
        logic [15:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic csr_wr(input logic [4:0] a, input logic [7:0] d);
        b1.csr_a = a;  b2.csr_a = a;
        b1.csr_di = d; b2.csr_di = d;
        b1.csr_we = 1'b1; b2.csr_we = 1'b1;
        @(negedge clk);
        b1.csr_we = 1'b0; b2.csr_we = 1'b0;
    endtask

    task automatic csr_rd(input int sel, input logic [4:0] a, output logic [7:0] d);
        b1.csr_a = a; b2.csr_a = a;
        #1;
        d = (sel == 1) ? b2.csr_do : b1.csr_do;
    endtask

    task automatic push(input int sel, input logic [15:0] val, input string tag);
        exp_t e;
        e.sel = sel; e.val = val; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        logic [7:0] h, l;
        check("sb_underflow", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            csr_rd(e.sel, BASE + 5'd1, h);
            csr_rd(e.sel, BASE + 5'd2, l);
            check(e.tag, {h, l}, e.val);
        end
    endtask

    task automatic gate();
        ce_1s = 1'b1;
        @(negedge clk);
        ce_1s = 1'b0;
    endtask

    task automatic pulse(input int lo, input int hi);
        tach_in = 1'b0;
        repeat (lo) @(negedge clk);
        tach_in = 1'b1;
        repeat (hi) @(negedge clk);
    endtask

    // Pin rise timed so the filtered edge lands exactly in the ce_1s cycle
    // (FILTER_LEN=4 instance: 2 sync + 4 filter cycles).
    task automatic edge_on_gate();
        tach_in = 1'b0;
        repeat (20) @(negedge clk);
        tach_in = 1'b1;
        repeat (6) @(negedge clk);
        gate();
    endtask

    logic [7:0] d;
    logic [4:0] bad_addr [4];

    initial begin
        b1.csr_a = '0; b1.csr_di = '0; b1.csr_we = 1'b0;
        b2.csr_a = '0; b2.csr_di = '0; b2.csr_we = 1'b0;
        bad_addr[0] = 5'h19; bad_addr[1] = 5'h1d; bad_addr[2] = 5'h1e; bad_addr[3] = 5'h0a;

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        csr_rd(0, BASE, d);          check("rst_ctrl", d, 8'h00);
        csr_rd(0, BASE + 5'd2, d);   check("rst_cnt_l", d, 8'h00);
        check("rst_irq", irq1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // basic count
        csr_wr(BASE, 8'h01);
        repeat (10) @(negedge clk);
        gate();
        csr_rd(0, BASE, d);          check("arm_valid", d[7], 1'b0);
        repeat (100) pulse(20, 20);
        gate();
        push(0, 16'd100, "basic_cnt");
        csr_rd(0, BASE, d);
        check("basic_valid", d[7], 1'b1);
        check("basic_stall", d[4], 1'b0);
        csr_rd(0, BASE + 5'd2, d);   check("basic_latency", d, 8'h00);
        @(negedge clk);
        sb_check();

        // glitch rejection, both filter lengths see the same pin
        for (int i = 0; i < 10; i++) begin
            pulse(20, 10);
            pulse(3, 10);
        end
        gate();
        push(0, 16'd10, "glitch_f4");
        push(1, 16'd20, "glitch_f2");
        @(negedge clk);
        sb_check();
        sb_check();

        // stall interrupt
        csr_wr(BASE, 8'h00);
        csr_wr(BASE, 8'h03);
        repeat (50) @(negedge clk);
        gate();
        csr_rd(0, BASE, d);
        check("stall_arm", d[4], 1'b0);
        check("irq_arm", irq1, 1'b0);
        repeat (50) @(negedge clk);
        gate();
        push(0, 16'd0, "stall_cnt");
        csr_rd(0, BASE, d);
        check("stall_set", d[4], 1'b1);
        check("stall_irq", irq1, 1'b1);
        @(negedge clk);
        sb_check();
        csr_wr(BASE, 8'h13);
        csr_rd(0, BASE, d);
        check("stall_w1c", d[4], 1'b0);
        check("irq_clr", irq1, 1'b0);
        repeat (50) @(negedge clk);
        gate();
        csr_rd(0, BASE, d);          check("stall_again", d[4], 1'b1);
        push(0, 16'd0, "stall_again_cnt");
        @(negedge clk);
        sb_check();
        repeat (20) @(negedge clk);
        b1.csr_a = BASE; b2.csr_a = BASE;
        b1.csr_di = 8'h13; b2.csr_di = 8'h13;
        b1.csr_we = 1'b1; b2.csr_we = 1'b1;
        ce_1s = 1'b1;
        @(negedge clk);
        b1.csr_we = 1'b0; b2.csr_we = 1'b0;
        ce_1s = 1'b0;
        csr_rd(0, BASE, d);          check("stall_set_wins", d[4], 1'b1);

        // edge on the gate strobe belongs to the ending gate
        repeat (4) pulse(20, 20);
        edge_on_gate();
        push(0, 16'd5, "edge_on_gate");
        @(negedge clk);
        sb_check();
        repeat (3) pulse(20, 20);
        gate();
        push(0, 16'd3, "next_gate");
        @(negedge clk);
        sb_check();

        // saturation of the running count and of the gate-end sum
        force dut.cnt = 16'hfffd;
        @(negedge clk);
        release dut.cnt;
        repeat (4) pulse(20, 20);
        gate();
        push(0, 16'hffff, "sat_cnt");
        @(negedge clk);
        sb_check();
        force dut.cnt = 16'hffff;
        @(negedge clk);
        release dut.cnt;
        edge_on_gate();
        push(0, 16'hffff, "sat_sum");
        @(negedge clk);
        sb_check();

        // freeze
        repeat (50) pulse(20, 20);
        gate();
        push(0, 16'h0032, "frz_base");
        @(negedge clk);
        sb_check();
        csr_wr(BASE, 8'h07);
        repeat (64) pulse(20, 20);
        gate();
        push(0, 16'h0032, "frz_hold");
        @(negedge clk);
        sb_check();
        csr_wr(BASE, 8'h03);
        csr_rd(0, BASE + 5'd2, d);   check("frz_clr_latency", d, 8'h32);
        push(0, 16'h0040, "frz_release");
        @(negedge clk);
        sb_check();

        // decode outside the window
        foreach (bad_addr[i]) begin
            csr_rd(0, bad_addr[i], d);
            check($sformatf("decode_%0h", bad_addr[i]), d, 8'h00);
        end

        // reset mid-gate
        check("irq_pre_rst", irq1, 1'b1);
        tach_in = 1'b0;
        repeat (5) @(negedge clk);
        #3 rst = 1'b0;
        csr_rd(0, BASE, d);          check("midrst_ctrl", d, 8'h00);
        csr_rd(0, BASE + 5'd2, d);   check("midrst_cnt_l", d, 8'h00);
        csr_rd(0, BASE + 5'd1, d);   check("midrst_cnt_h", d, 8'h00);
        check("midrst_irq", irq1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tach_in = 1'b1;
        @(negedge clk);
        csr_rd(0, BASE, d);          check("post_rst_ctrl", d, 8'h00);
        repeat (5) pulse(20, 20);
        gate();
        push(0, 16'd0, "post_rst_cnt");
        @(negedge clk);
        sb_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
